// File: rtl/audio_pkg.sv
// audio_pkg: I2S format constants and stereo sample type shared by the codec DAC and ADC paths.
package audio_pkg;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_SLOT_W = 32;
    localparam int I2S_MSB_DELAY = 1;
    localparam logic I2S_LEFT_LRCK = 1'b0;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] left;
        logic [DEF_DATA_W-1:0] right;
    } stereo_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered full/empty/level flags.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level_n;
    logic do_push, do_pop;

    always_comb begin
        do_push = push & ~full;
        do_pop = pop & ~empty;
        level_n = level + LW'(do_push) - LW'(do_pop);
    end

    assign dout = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
            full <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level_n;
            full <= level_n == LW'(DEPTH);
            empty <= level_n == '0;
        end
    end
endmodule

// File: rtl/audio_i2s_dac_tx.sv
// audio_i2s_dac_tx: I2S master serializer driving WM8731 DAC pins from a stereo sample FIFO.
module audio_i2s_dac_tx
    import audio_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int SLOT_W = DEF_SLOT_W,
    parameter int BCLK_HALF = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLOCK_50,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_W-1:0]             s_left,
    input  logic [DATA_W-1:0]             s_right,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    output logic                          aud_bclk,
    output logic                          aud_daclrck,
    output logic                          aud_dacdat
);
    localparam int B_W = $clog2(2*SLOT_W);
    localparam int C_W = $clog2(BCLK_HALF);
    localparam logic [B_W-1:0] B_LAST = B_W'(2*SLOT_W-1);
    localparam logic [DATA_W-1:0] MSB = {1'b1, {(DATA_W-1){1'b0}}};

    typedef struct packed {
        logic [DATA_W-1:0] left;
        logic [DATA_W-1:0] right;
    } pair_t;

    logic [C_W-1:0] cnt, cnt_n;
    logic [B_W-1:0] b, b_n, nb, k;
    pair_t hold, hold_n, fifo_dout;
    logic bclk_n, lrck_n, dat_n, ur_n;
    logic tc, fall, frame_start, right, full, empty;

    sync_fifo #(.WIDTH(2*DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(CLOCK_50),
        .rst_n(reset_n),
        .push(s_valid & s_ready),
        .pop(frame_start),
        .din({s_left, s_right}),
        .dout(fifo_dout),
        .full(full),
        .empty(empty),
        .level(fifo_level)
    );

    assign s_ready = ~full;

    always_comb begin
        tc = cnt == C_W'(BCLK_HALF-1);
        fall = enable & tc & aud_bclk;
        nb = (b == B_LAST) ? '0 : b + 1'b1;
        frame_start = fall & (nb == '0);
        right = nb >= B_W'(SLOT_W);
        k = right ? nb - B_W'(SLOT_W) : nb;
        cnt_n = (!enable || tc) ? '0 : cnt + 1'b1;
        bclk_n = enable & (aud_bclk ^ tc);
        b_n = !enable ? B_LAST : fall ? nb : b;
        lrck_n = enable & (fall ? (right ? ~I2S_LEFT_LRCK : I2S_LEFT_LRCK) : aud_daclrck);
        // Mask walks MSB-first; k below the MSB delay wraps the shift past the width and yields 0.
        dat_n = enable & (fall ? |((right ? hold.right : hold.left) & (MSB >> (k - B_W'(I2S_MSB_DELAY))))
                               : aud_dacdat);
        hold_n = !enable ? '0 : frame_start ? (empty ? '0 : fifo_dout) : hold;
        ur_n = frame_start & empty;
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            b <= B_LAST;
            hold <= '0;
            aud_bclk <= 1'b0;
            aud_daclrck <= 1'b0;
            aud_dacdat <= 1'b0;
            underrun <= 1'b0;
        end else begin
            cnt <= cnt_n;
            b <= b_n;
            hold <= hold_n;
            aud_bclk <= bclk_n;
            aud_daclrck <= lrck_n;
            aud_dacdat <= dat_n;
            underrun <= ur_n;
        end
    end
endmodule

// File: doc/audio_i2s_dac_tx.md
# audio_i2s_dac_tx

Transmit-side audio serializer for the WM8731 codec. The FPGA is the bus master: the block generates AUD_BCLK and AUD_DACLRCK from the system clock. It serializes buffered stereo PCM samples onto AUD_DACDAT in I2S format. It sits between a stream source (Nios PIO/DMA bridge or tone generator) and the codec DAC pins, complementing the existing ADC capture path.

## Interface
Parameters:
- DATA_W, 16, bits per channel sample; constraint DATA_W <= SLOT_W-1
- SLOT_W, 32, BCLK periods per channel slot; a frame is 2*SLOT_W BCLKs
- BCLK_HALF, 16, CLOCK_50 cycles per BCLK half-period; must be >= 2
- FIFO_DEPTH, 4, stereo pairs buffered; power of 2

Ports:
- CLOCK_50  in  1  system clock; sole clock domain
- reset_n  in  1  reset, asynchronous assert, active-low
- enable  in  1  run serializer; low = idle
- s_valid  in  1  sample pair offered
- s_ready  out  1  FIFO can accept; equals !full (registered)
- s_left  in  DATA_W  left sample, two's complement
- s_right  in  DATA_W  right sample
- fifo_level  out  $clog2(FIFO_DEPTH)+1  pairs currently stored
- underrun  out  1  one-cycle pulse when a frame starts with the FIFO empty
- aud_bclk  out  1  to AUD_BCLK
- aud_daclrck  out  1  to AUD_DACLRCK; 0 = left slot
- aud_dacdat  out  1  to AUD_DACDAT

## Operation
- Reset values: aud_bclk=0, aud_daclrck=0, aud_dacdat=0, underrun=0, s_ready=1, fifo_level=0.
- Counters and holding register after reset:
  - divider count = 0
  - bit index b = 2*SLOT_W-1
  - holding pair = 0
- Push rules:
  - A push occurs on s_valid & s_ready.
  - When full, s_ready is low; s_valid is ignored.
- Enable low:
  - The divider is held at 0; b is forced to 2*SLOT_W-1.
  - aud_bclk, aud_daclrck and aud_dacdat are held at 0; the holding pair is cleared.
  - FIFO contents are kept, and pushes are still accepted.
- Deasserting enable mid-frame aborts the frame in the next cycle with no completion.
- BCLK generation, with enable high:
  - The divider counts 0..BCLK_HALF-1.
  - On the terminal count, aud_bclk toggles and the divider wraps.
  - A 1->0 toggle is a fall event.
- On each fall event:
  - b increments, wrapping 2*SLOT_W-1 -> 0.
  - aud_daclrck <= (new b >= SLOT_W).
  - Slot bit k = new b mod SLOT_W.
  - aud_dacdat <= channel bit DATA_W-k when 1 <= k <= DATA_W, else 0. The channel is left when b < SLOT_W, otherwise right.
  - This gives I2S format: MSB one BCLK after the LRCK edge, padding is zero, and data changes on the BCLK falling edge.
- Frame start (fall event with b wrapping to 0):
  - If the FIFO is non-empty: pop one pair into the holding register.
  - If the FIFO is empty: load the holding register with 0 and pulse underrun for one cycle.
  - A push in the same cycle does not bypass the FIFO.
- Simultaneous push and pop when not full: both take effect; fifo_level is unchanged.

## Timing
- All outputs are registered; aud_bclk, aud_daclrck and aud_dacdat change on the same CLOCK_50 edge.
- After enable rises:
  - First BCLK rise occurs BCLK_HALF cycles later.
  - First fall event (frame start) occurs 2*BCLK_HALF cycles later.
- Frame length is 2*SLOT_W*2*BCLK_HALF cycles. Defaults give 2048 cycles, i.e. fs = 24.414 kHz.
- Sample-to-pin latency:
  - A pair is popped at the frame start following its push.
  - Its left MSB appears on the next fall event, 2*BCLK_HALF cycles after the pop.
- s_ready and fifo_level update one cycle after the push or pop.
- Reset asserted mid-frame: all state returns to reset values asynchronously.

## Structure
- Package audio_pkg holds:
  - I2S format constants (MSB delay = 1, left = LRCK low)
  - stereo sample struct {left, right}
  - default DATA_W/SLOT_W values, shared with the ADC capture block
- Sub-module sync_fifo (parameterized width/depth, registered full/empty/level). The serializer FSM and clock divider stay in the top module.

## Test plan
Bench parameters: DATA_W=16, SLOT_W=32, BCLK_HALF=2.
- Reset, then enable with no pushes:
  - first fall event at cycle 4 → underrun pulse
  - aud_dacdat stays 0
  - aud_daclrck toggles every 32 BCLKs (128 cycles)
- Push L=0xA5A5, R=0x0F0F, then enable:
  - left slot bits 1..16 = 1010010110100101
  - right slot bits 1..16 = 0000111100001111
  - all other bits 0
- Push 5 pairs back-to-back with enable low:
  - 4 accepted
  - s_ready low after the 4th
  - fifo_level=4
  - the 5th is held off until the first frame-start pop
- Continuous source at fs → no underrun for 100 frames; then starve the source → underrun pulses exactly once per frame.
- Drop enable at b=40 → next cycle all three pins are 0. Re-enable → a new frame starts with the next queued pair, and the aborted pair is not resent.
- Assert reset_n low mid-frame with the FIFO holding 3 pairs → all outputs and fifo_level go to 0 immediately, and s_ready=1.
